// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin sharing of one synchronous ROM read port
// between two requesters, with a single transaction in flight.
module rom_port_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(ROM_LAT - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic       ptr;
    logic       sel;
    logic       pick;
    logic       any_req;
    logic       last_wait;

    // ptr=1 favours port 1 when both ports request
    assign any_req   = req0 | req1;
    assign pick      = req1 & (~req0 | ptr);
    assign last_wait = (cnt == 2'd0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (last_wait) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            busy     <= 1'b0;
            cnt      <= 2'd0;
            ptr      <= 1'b0;
            sel      <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rom_en  <= 1'b0;
            busy    <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel      <= pick;
                        gnt0     <= ~pick;
                        gnt1     <= pick;
                        rom_en   <= 1'b1;
                        rom_addr <= pick ? addr1 : addr0;
                    end
                end
                ISSUE: begin
                    ptr <= ~sel;
                    cnt <= LAT_LOAD;
                end
                WAIT: begin
                    if (last_wait) begin
                        if (sel) rdata1 <= rom_data;
                        else     rdata0 <= rom_data;
                        rvalid0 <= ~sel;
                        rvalid1 <= sel;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: ROM_LAT=1 and ROM_LAT=3 instances, vector
// table, hand sequences and a randomized run against a timeline model.
module tb_rom_port_arbiter;
    localparam int N_RAND = 600;
    localparam int N_ARR  = N_RAND + 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       r0, r1, sel3;
    logic [4:0] a0, a1;

    logic       g0_1, g1_1, v0_1, v1_1, en_1, busy_1;
    logic [7:0] d0_1, d1_1, rd_1;
    logic [4:0] ra_1;
    logic       g0_3, g1_3, v0_3, v1_3, en_3, busy_3;
    logic [7:0] d0_3, d1_3, rd_3, p3_0, p3_1;
    logic [4:0] ra_3;

    logic       g0, g1, v0, v1, en, busy;
    logic [7:0] d0, d1;
    logic [4:0] ra;

    int tests = 0;
    int fails = 0;

    function automatic logic [7:0] rom_f(input logic [4:0] a);
        if (a == 5'd3) return 8'hA5;
        return ({3'b000, a} * 8'd29) ^ 8'h5C;
    endfunction

    rom_port_arbiter #(.ADDR_W(5), .DATA_W(8), .ROM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .req0(r0 & ~sel3), .addr0(a0), .gnt0(g0_1),
        .rvalid0(v0_1), .rdata0(d0_1),
        .req1(r1 & ~sel3), .addr1(a1), .gnt1(g1_1),
        .rvalid1(v1_1), .rdata1(d1_1),
        .rom_en(en_1), .rom_addr(ra_1), .rom_data(rd_1), .busy(busy_1)
    );

    rom_port_arbiter #(.ADDR_W(5), .DATA_W(8), .ROM_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0(r0 & sel3), .addr0(a0), .gnt0(g0_3),
        .rvalid0(v0_3), .rdata0(d0_3),
        .req1(r1 & sel3), .addr1(a1), .gnt1(g1_3),
        .rvalid1(v1_3), .rdata1(d1_3),
        .rom_en(en_3), .rom_addr(ra_3), .rom_data(rd_3), .busy(busy_3)
    );

    // synchronous ROMs with 1 and 3 cycles of read latency
    always @(posedge clk) begin
        rd_1 <= rom_f(ra_1);
        p3_0 <= rom_f(ra_3);
        p3_1 <= p3_0;
        rd_3 <= p3_1;
    end

    assign g0   = sel3 ? g0_3 : g0_1;
    assign g1   = sel3 ? g1_3 : g1_1;
    assign v0   = sel3 ? v0_3 : v0_1;
    assign v1   = sel3 ? v1_3 : v1_1;
    assign en   = sel3 ? en_3 : en_1;
    assign busy = sel3 ? busy_3 : busy_1;
    assign d0   = sel3 ? d0_3 : d0_1;
    assign d1   = sel3 ? d1_3 : d1_1;
    assign ra   = sel3 ? ra_3 : ra_1;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        r0 = 1'b0;
        r1 = 1'b0;
        #1;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    function automatic logic [26:0] outs();
        return {g0, g1, v0, v1, en, busy, ra, d0, d1};
    endfunction

    task automatic single_read(input bit port, input logic [4:0] addr,
                               output int gl, output int rl,
                               output int ec, output int bc,
                               output logic [7:0] data,
                               output logic [4:0] ga, output int wrong);
        gl = -1; rl = -1; ec = 0; bc = 0; wrong = 0;
        data = 8'h00; ga = 5'h00;
        if (port) begin r1 = 1'b1; a1 = addr; end
        else      begin r0 = 1'b1; a0 = addr; end
        for (int k = 1; k <= 20 && rl < 0; k++) begin
            tick;
            if (en) begin ec++; ga = ra; end
            if (busy) bc++;
            if (port ? (g0 | v0) : (g1 | v1)) wrong++;
            if (port ? g1 : g0) begin
                gl = k;
                // address moves after the grant; the read must not follow it
                if (port) begin r1 = 1'b0; a1 = ~addr; end
                else      begin r0 = 1'b0; a0 = ~addr; end
            end
            if (port ? v1 : v0) begin
                rl = k;
                data = port ? d1 : d0;
            end
        end
        r0 = 1'b0;
        r1 = 1'b0;
        tick;
    endtask

    typedef struct {
        bit         lat3;
        bit         port;
        logic [4:0] addr;
        int         gl;
        int         rl;
        logic [7:0] data;
    } vec_t;

    vec_t vt[8];

    task automatic alternate(input bit lat3, input int n);
        int n0, n1, bad, seen;
        bit expect_p, p;
        sel3 = lat3;
        do_reset;
        n0 = 0; n1 = 0; bad = 0; expect_p = 1'b0;
        r0 = 1'b1; r1 = 1'b1;
        a0 = 5'($urandom); a1 = 5'($urandom);
        for (int g = 0; g < n; g++) begin
            seen = 0;
            for (int k = 0; k < 20 && seen == 0; k++) begin
                tick;
                if (g0 & g1) bad++;
                if (g0 | g1) seen = 1;
            end
            p = g1;
            check($sformatf("alt_l%0d_g%0d_seen", lat3 ? 3 : 1, g),
                  64'(seen), 64'd1);
            check($sformatf("alt_l%0d_g%0d_port", lat3 ? 3 : 1, g),
                  64'(p), 64'(expect_p));
            if (p) begin n1++; r1 = 1'b0; end
            else   begin n0++; r0 = 1'b0; end
            tick;
            r0 = 1'b1; r1 = 1'b1;
            a0 = 5'($urandom); a1 = 5'($urandom);
            expect_p = ~p;
        end
        check("alt_balance", 64'((n0 > n1 ? n0 - n1 : n1 - n0) <= 1), 64'd1);
        check("alt_both_gnt", 64'(bad), 64'd0);
        r0 = 1'b0; r1 = 1'b0;
        for (int k = 0; k < 8; k++) tick;
    endtask

    task automatic reset_mid_wait(input bit lat3);
        int gl, rl, ec, bc, wrong, seen, act;
        logic [7:0] data;
        logic [4:0] ga;
        sel3 = lat3;
        r0 = 1'b1;
        a0 = 5'd7;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            tick;
            if (g0) seen = 1;
        end
        check("rst_mid_gnt", 64'(seen), 64'd1);
        r0 = 1'b0;
        tick;
        check("rst_mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_outs", 64'(outs()), 64'd0);
        tick;
        tick;
        reset = 1'b0;
        act = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (g0 | g1 | v0 | v1 | en | busy) act++;
        end
        check("rst_no_resp", 64'(act), 64'd0);
        single_read(1'b1, 5'd9, gl, rl, ec, bc, data, ga, wrong);
        check("rst_next_gl", 64'(gl), 64'd1);
        check("rst_next_rl", 64'(rl), 64'(lat3 ? 5 : 3));
        check("rst_next_data", 64'(data), 64'(rom_f(5'd9)));
    endtask

    bit         eg0[N_ARR], eg1[N_ARR], ev0[N_ARR], ev1[N_ARR];
    bit         een[N_ARR], ebusy[N_ARR];
    bit         ura[N_ARR], urd0[N_ARR], urd1[N_ARR];
    logic [4:0] vra[N_ARR];
    logic [7:0] vrd0[N_ARR], vrd1[N_ARR];

    // Timeline model: a request seen at cycle c while the port is free is
    // granted at c+1, answered at c+2+L, and the port frees at c+3+L.
    task automatic run_random(input bit lat3, input bit hold1);
        int L, free, tr;
        bit ptr, pend0, pend1, w;
        logic [4:0] wa, cra;
        logic [7:0] crd0, crd1;
        logic [26:0] exp;
        sel3 = lat3;
        L = lat3 ? 3 : 1;
        for (int i = 0; i < N_ARR; i++) begin
            eg0[i] = 0; eg1[i] = 0; ev0[i] = 0; ev1[i] = 0;
            een[i] = 0; ebusy[i] = 0; ura[i] = 0; urd0[i] = 0;
            urd1[i] = 0; vra[i] = 0; vrd0[i] = 0; vrd1[i] = 0;
        end
        do_reset;
        free = 0; ptr = 0; pend0 = 0; pend1 = 0;
        cra = 0; crd0 = 0; crd1 = 0;
        for (int c = 0; c < N_RAND; c++) begin
            if (c > 0) tick;
            if (ura[c])  cra  = vra[c];
            if (urd0[c]) crd0 = vrd0[c];
            if (urd1[c]) crd1 = vrd1[c];
            exp = {eg0[c], eg1[c], ev0[c], ev1[c], een[c], ebusy[c],
                   cra, crd0, crd1};
            check($sformatf("rand_l%0d_h%0d_c%0d", L, hold1, c),
                  64'(outs()), 64'(exp));
            if (eg0[c]) begin pend0 = 0; r0 = 1'b0; end
            if (eg1[c]) begin pend1 = 0; r1 = 1'b0; end
            if (!pend0) begin
                a0 = 5'($urandom);
                if ($urandom_range(3) == 0) begin pend0 = 1; r0 = 1'b1; end
            end
            if (!pend1) begin
                a1 = 5'($urandom);
                if (hold1 || $urandom_range(2) == 0) begin
                    pend1 = 1;
                    r1 = 1'b1;
                end
            end
            if (c >= free && (r0 || r1)) begin
                w  = r1 && (!r0 || ptr);
                ptr = !w;
                wa = w ? a1 : a0;
                tr = c + 2 + L;
                if (w) eg1[c+1] = 1;
                else   eg0[c+1] = 1;
                een[c+1] = 1;
                ura[c+1] = 1;
                vra[c+1] = wa;
                for (int k = c + 1; k <= tr; k++) ebusy[k] = 1;
                if (w) begin ev1[tr] = 1; urd1[tr] = 1; vrd1[tr] = rom_f(wa); end
                else   begin ev0[tr] = 1; urd0[tr] = 1; vrd0[tr] = rom_f(wa); end
                free = c + 3 + L;
            end
        end
        r0 = 1'b0;
        r1 = 1'b0;
        for (int k = 0; k < 8; k++) tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gl, rl, ec, bc, wrong;
        logic [7:0] data;
        logic [4:0] ga;

        reset = 1'b1;
        r0 = 1'b0; r1 = 1'b0;
        a0 = 5'd0; a1 = 5'd0;
        sel3 = 1'b0;

        vt[0] = '{1'b0, 1'b0, 5'd3,  1, 3, 8'hA5};
        vt[1] = '{1'b0, 1'b1, 5'd3,  1, 3, 8'hA5};
        vt[2] = '{1'b0, 1'b0, 5'd0,  1, 3, rom_f(5'd0)};
        vt[3] = '{1'b0, 1'b0, 5'd31, 1, 3, rom_f(5'd31)};
        vt[4] = '{1'b0, 1'b1, 5'd31, 1, 3, rom_f(5'd31)};
        vt[5] = '{1'b1, 1'b0, 5'd31, 1, 5, rom_f(5'd31)};
        vt[6] = '{1'b1, 1'b1, 5'd0,  1, 5, rom_f(5'd0)};
        vt[7] = '{1'b1, 1'b0, 5'd3,  1, 5, 8'hA5};

        tick;
        check("reset_state_l1", 64'(outs()), 64'd0);
        sel3 = 1'b1;
        #1;
        check("reset_state_l3", 64'(outs()), 64'd0);
        sel3 = 1'b0;
        reset = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) begin
            sel3 = vt[i].lat3;
            single_read(vt[i].port, vt[i].addr, gl, rl, ec, bc, data, ga, wrong);
            check($sformatf("vec%0d_gnt_lat", i), 64'(gl), 64'(vt[i].gl));
            check($sformatf("vec%0d_rv_lat", i), 64'(rl), 64'(vt[i].rl));
            check($sformatf("vec%0d_data", i), 64'(data), 64'(vt[i].data));
            check($sformatf("vec%0d_rom_en", i), 64'(ec), 64'd1);
            check($sformatf("vec%0d_rom_addr", i), 64'(ga), 64'(vt[i].addr));
            check($sformatf("vec%0d_busy_cnt", i), 64'(bc), 64'(vt[i].rl));
            check($sformatf("vec%0d_wrong_port", i), 64'(wrong), 64'd0);
            check($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_hold", i),
                  64'(vt[i].port ? d1 : d0), 64'(vt[i].data));
        end

        alternate(1'b0, 100);
        alternate(1'b1, 10);
        reset_mid_wait(1'b0);
        reset_mid_wait(1'b1);
        run_random(1'b0, 1'b0);
        run_random(1'b0, 1'b1);
        run_random(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
